stopwatch_bcd_n: RTL

//  Parametrised N-digit BCD stopwatch driving active-low 7-segment displays.

---
 rtl/stopwatch_pkg.sv | 35 +++
 rtl/btn_sync_edge.sv | 30 +++
 rtl/stopwatch_bcd_n.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, constants and the 7-segment decoder for the BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    STOPPED = 2'd1,
    RUNNING = 2'd2,
    HOLD    = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEG_W     = 7;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  // Active-low gfedcba pattern; anything outside 0..9 blanks the digit.
  function automatic logic [6:0] bcd_to_seg7(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises an active-low push-button and emits a one-cycle pulse on its falling edge.
module btn_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_fall;

  // Reset to the released level so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_fall <= r_prev & ~r_sync[SYNC_STAGES-1];
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/stopwatch_bcd_n.sv
// N-digit BCD stopwatch with button-driven control FSM and active-low 7-segment outputs.
// Optional feature: define SW_AUTOSTOP_EN to freeze at all-9s instead of wrapping.
module stopwatch_bcd_n
  import stopwatch_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 10,
  parameter int unsigned DP_DIGIT    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_start_n,
  input  logic                  btn_reset_n,
  input  logic                  btn_run_n,
  input  logic                  btn_hold_n,
  input  logic                  btn_stop_n,
  output logic [7*N_DIGITS-1:0] seg_n,
  output logic [N_DIGITS-1:0]   dp_n,
  output logic [1:0]            state_o
);

  localparam int unsigned TC    = CLK_HZ / TICK_HZ - 1;
  localparam int unsigned DIV_W = (TC > 0) ? $clog2(TC + 1) : 1;

`ifdef SW_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  sw_state_t                 r_state;
  bcd_t [N_DIGITS-1:0]       r_digit;
  bcd_t [N_DIGITS-1:0]       r_held;
  logic [DIV_W-1:0]          r_div;

  logic [4:0]                w_btn_n;
  logic [4:0]                w_ev;
  logic                      w_stop, w_rst, w_run, w_hold, w_start;
  logic                      w_active, w_tick, w_all9, w_autostop, w_run_ok;
  logic [N_DIGITS-1:0]       w_carry;
  logic [N_DIGITS-1:0]       w_nine;
  bcd_t [N_DIGITS-1:0]       w_digit_inc;

  assign w_btn_n = {btn_stop_n, btn_reset_n, btn_run_n, btn_hold_n, btn_start_n};

  for (genvar b = 0; b < 5; b++) begin : g_btn
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn_n (w_btn_n[b]),
      .o_fall  (w_ev[b])
    );
  end

  // Strict priority: stop > reset > run > hold > start; only the winner acts.
  assign w_stop  = w_ev[4];
  assign w_rst   = w_ev[3] & ~w_ev[4];
  assign w_run   = w_ev[2] & ~(|w_ev[4:3]);
  assign w_hold  = w_ev[1] & ~(|w_ev[4:2]);
  assign w_start = w_ev[0] & ~(|w_ev[4:1]);

  assign w_active   = (r_state == RUNNING) || (r_state == HOLD);
  assign w_tick     = w_active && (r_div == DIV_W'(TC));
  assign w_all9     = &w_nine;
  assign w_autostop = AUTOSTOP && w_tick && w_all9;
  assign w_run_ok   = !(AUTOSTOP && w_all9);

  // Ripple carry: a digit advances only when every lower digit is 9.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    assign w_nine[i] = (r_digit[i] == 4'd9);
    if (i == 0) begin : g_lsd
      assign w_carry[i] = w_tick;
    end else begin : g_upper
      assign w_carry[i] = w_carry[i-1] & w_nine[i-1];
    end
    assign w_digit_inc[i] = !w_carry[i] ? r_digit[i] :
                            (w_nine[i] ? 4'd0 : r_digit[i] + 4'd1);
  end

  // Control FSM with divider and digit registers; later assignments take precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_digit <= '0;
      r_held  <= '0;
      r_div   <= '0;
    end else begin
      if (w_active) begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      end
      if (w_tick && !w_autostop) begin
        r_digit <= w_digit_inc;
      end
      case (r_state)
        OFF: begin
          if (w_start) r_state <= STOPPED;
        end
        STOPPED: begin
          if (w_stop)                  r_state <= OFF;
          else if (w_rst)              r_digit <= '0;
          else if (w_run && w_run_ok)  r_state <= RUNNING;
        end
        RUNNING: begin
          if (w_stop) begin
            r_state <= OFF;
          end else if (w_rst) begin
            r_digit <= '0;
            r_div   <= '0;
            r_state <= STOPPED;
          end else if (w_hold) begin
            r_held  <= r_digit;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_stop) begin
            r_state <= OFF;
          end else if (w_rst) begin
            r_digit <= '0;
            r_div   <= '0;
            r_state <= STOPPED;
          end else if (w_run && w_run_ok) begin
            r_state <= RUNNING;
          end else if (w_hold) begin
            r_held  <= r_digit;
          end
        end
        default: r_state <= OFF;
      endcase
      if (w_autostop && !w_stop && !w_rst) begin
        r_state <= STOPPED;
      end
    end
  end

  // Display decode from registered state and digit sources.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_seg
    bcd_t w_src;
    assign w_src = (r_state == HOLD) ? r_held[i] : r_digit[i];
    assign seg_n[SEG_W*i +: SEG_W] = (r_state == OFF) ? SEG_BLANK : bcd_to_seg7(w_src);
  end

  always_comb begin
    dp_n           = '1;
    dp_n[DP_DIGIT] = (r_state == OFF);
  end

  assign state_o = 2'(r_state);

endmodule
